// File: rtl/tpu_uart_pkg.sv
// Shared opcodes, FSM states and readback lengths for the UART command controller.
package tpu_uart_pkg;

    typedef enum logic [7:0] {
        OP_W_COL0    = 8'h01,
        OP_W_COL1    = 8'h02,
        OP_ACT       = 8'h03,
        OP_WREADY    = 8'h04,
        OP_START     = 8'h05,
        OP_RD_STATUS = 8'h06,
        OP_RD_ACC    = 8'h07,
        OP_WF_RESET  = 8'h08,
        OP_CLR_ERR   = 8'h09
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_WDATA,
        ST_ACT_LO,
        ST_ACT_HI,
        ST_TX
    } state_e;

    localparam logic [3:0] RD_STATUS_LEN = 4'd2;
    localparam logic [3:0] RD_ACC_LEN    = 4'd8;

endpackage

// File: rtl/cmd_tx_sequencer.sv
// Holds a 64-bit readback snapshot and streams its low bytes out over the
// valid/ready TX handshake, least significant byte first.
module cmd_tx_sequencer
    import tpu_uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [3:0]  len_i,
    input  logic [63:0] snap_i,
    input  logic        tx_ready_i,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    output logic        done_o
);

    logic [63:0] snap_q, snap_d;
    logic [3:0]  left_q, left_d;
    logic        valid_q, valid_d;

    always_comb begin
        snap_d  = snap_q;
        left_d  = left_q;
        valid_d = valid_q;
        if (load_i) begin
            snap_d  = snap_i;
            left_d  = len_i;
            valid_d = (len_i != 4'd0);
        end else if (valid_q && tx_ready_i) begin
            // Shift the next byte into the output slot so it is presented without a bubble.
            snap_d = {8'h00, snap_q[63:8]};
            left_d = left_q - 4'd1;
            if (left_q == 4'd1) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q  <= '0;
            left_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            snap_q  <= snap_d;
            left_q  <= left_d;
            valid_q <= valid_d;
        end
    end

    assign tx_valid_o = valid_q;
    assign tx_data_o  = snap_q[7:0];
    assign done_o     = valid_q && tx_ready_i && (left_q == 4'd1);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART byte-stream command decoder driving the TPU bridge ctrl_* inputs.
// Optional inter-byte timeout enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_ctrl
    import tpu_uart_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic [7:0]         tx_data,
    output logic               ctrl_wf_push_col0,
    output logic               ctrl_wf_push_col1,
    output logic [7:0]         ctrl_wf_data_in,
    output logic               ctrl_wf_reset,
    output logic               ctrl_init_act_valid,
    output logic [15:0]        ctrl_init_act_data,
    output logic               ctrl_start_mlp,
    output logic               ctrl_weights_ready,
    input  logic [3:0]         mlp_state,
    input  logic [4:0]         mlp_cycle_cnt,
    input  logic signed [31:0] mlp_acc0,
    input  logic signed [31:0] mlp_acc1,
    output logic               err_overrun,
    output logic               err_badop
);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        col_q, col_d;
    logic [7:0]  lo_q, lo_d;
    logic        push0_q, push0_d, push1_q, push1_d;
    logic        wrst_q, wrst_d, actv_q, actv_d;
    logic        start_q, start_d, wrdy_q, wrdy_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [15:0] actd_q, actd_d;
    logic        ovr_q, ovr_d, bad_q, bad_d;
    logic        ovr_set, bad_set, err_clr;
    logic        tx_load, tx_done;
    logic [3:0]  tx_len;
    logic [63:0] tx_snap;
    logic        tmo_hit;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             wait_st;

    assign wait_st = (state_q == ST_LEN) || (state_q == ST_WDATA) ||
                     (state_q == ST_ACT_LO) || (state_q == ST_ACT_HI);
    assign tmo_d   = (!wait_st || rx_valid) ? '0 : tmo_q + 1'b1;
    assign tmo_hit = wait_st && !rx_valid && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = 1'b0;
    // Elaboration-only reference; there is no timer in this build.
    if (TIMEOUT_CYCLES < 1) begin : g_tmo_unused
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        lo_d    = lo_q;
        push0_d = 1'b0;
        push1_d = 1'b0;
        wrst_d  = 1'b0;
        actv_d  = 1'b0;
        start_d = 1'b0;
        wrdy_d  = 1'b0;
        wdata_d = wdata_q;
        actd_d  = actd_q;
        ovr_set = 1'b0;
        bad_set = 1'b0;
        err_clr = 1'b0;
        tx_load = 1'b0;
        tx_len  = 4'd0;
        tx_snap = '0;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        OP_W_COL0, OP_W_COL1: begin
                            col_d   = rx_data[1];
                            state_d = ST_LEN;
                        end
                        OP_ACT:      state_d = ST_ACT_LO;
                        OP_WREADY:   wrdy_d  = 1'b1;
                        OP_START:    start_d = 1'b1;
                        OP_WF_RESET: wrst_d  = 1'b1;
                        OP_CLR_ERR:  err_clr = 1'b1;
                        OP_RD_STATUS: begin
                            tx_load = 1'b1;
                            tx_len  = RD_STATUS_LEN;
                            tx_snap = {48'h0, ovr_q, bad_q, 1'b0, mlp_cycle_cnt, 4'h0, mlp_state};
                            state_d = ST_TX;
                        end
                        OP_RD_ACC: begin
                            tx_load = 1'b1;
                            tx_len  = RD_ACC_LEN;
                            tx_snap = {mlp_acc1, mlp_acc0};
                            state_d = ST_TX;
                        end
                        default:     bad_set = 1'b1;
                    endcase
                end
            end
            ST_LEN: begin
                if (rx_valid) begin
                    cnt_d   = rx_data;
                    state_d = (rx_data == 8'd0) ? ST_IDLE : ST_WDATA;
                end
            end
            ST_WDATA: begin
                if (rx_valid) begin
                    push0_d = !col_q;
                    push1_d = col_q;
                    wdata_d = rx_data;
                    cnt_d   = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = ST_IDLE;
                end
            end
            ST_ACT_LO: begin
                if (rx_valid) begin
                    lo_d    = rx_data;
                    state_d = ST_ACT_HI;
                end
            end
            ST_ACT_HI: begin
                if (rx_valid) begin
                    actv_d  = 1'b1;
                    actd_d  = {rx_data, lo_q};
                    state_d = ST_IDLE;
                end
            end
            ST_TX: begin
                // The sender is not allowed to talk over a readback; drop and flag.
                if (rx_valid) ovr_set = 1'b1;
                if (tx_done)  state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (tmo_hit) begin
            state_d = ST_IDLE;
            bad_set = 1'b1;
        end
    end

    assign ovr_d = ovr_set ? 1'b1 : (err_clr ? 1'b0 : ovr_q);
    assign bad_d = bad_set ? 1'b1 : (err_clr ? 1'b0 : bad_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            col_q   <= 1'b0;
            lo_q    <= '0;
            push0_q <= 1'b0;
            push1_q <= 1'b0;
            wrst_q  <= 1'b0;
            actv_q  <= 1'b0;
            start_q <= 1'b0;
            wrdy_q  <= 1'b0;
            wdata_q <= '0;
            actd_q  <= '0;
            ovr_q   <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            lo_q    <= lo_d;
            push0_q <= push0_d;
            push1_q <= push1_d;
            wrst_q  <= wrst_d;
            actv_q  <= actv_d;
            start_q <= start_d;
            wrdy_q  <= wrdy_d;
            wdata_q <= wdata_d;
            actd_q  <= actd_d;
            ovr_q   <= ovr_d;
            bad_q   <= bad_d;
        end
    end

    cmd_tx_sequencer u_tx (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tx_load),
        .len_i      (tx_len),
        .snap_i     (tx_snap),
        .tx_ready_i (tx_ready),
        .tx_valid_o (tx_valid),
        .tx_data_o  (tx_data),
        .done_o     (tx_done)
    );

    assign ctrl_wf_push_col0   = push0_q;
    assign ctrl_wf_push_col1   = push1_q;
    assign ctrl_wf_data_in     = wdata_q;
    assign ctrl_wf_reset       = wrst_q;
    assign ctrl_init_act_valid = actv_q;
    assign ctrl_init_act_data  = actd_q;
    assign ctrl_start_mlp      = start_q;
    assign ctrl_weights_ready  = wrdy_q;
    assign err_overrun         = ovr_q;
    assign err_badop           = bad_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Randomized bench for uart_cmd_ctrl against a command-buffer reference model.
module tb_uart_cmd_ctrl;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               rx_valid = 1'b0;
    logic [7:0]         rx_data = 8'h00;
    logic               tx_valid;
    logic               tx_ready = 1'b0;
    logic [7:0]         tx_data;
    logic               ctrl_wf_push_col0, ctrl_wf_push_col1, ctrl_wf_reset;
    logic [7:0]         ctrl_wf_data_in;
    logic               ctrl_init_act_valid;
    logic [15:0]        ctrl_init_act_data;
    logic               ctrl_start_mlp, ctrl_weights_ready;
    logic [3:0]         mlp_state = 4'h0;
    logic [4:0]         mlp_cycle_cnt = 5'h0;
    logic signed [31:0] mlp_acc0 = 32'sd0;
    logic signed [31:0] mlp_acc1 = 32'sd0;
    logic               err_overrun, err_badop;

    always #5 clk = ~clk;

    uart_cmd_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .ctrl_wf_push_col0(ctrl_wf_push_col0), .ctrl_wf_push_col1(ctrl_wf_push_col1),
        .ctrl_wf_data_in(ctrl_wf_data_in), .ctrl_wf_reset(ctrl_wf_reset),
        .ctrl_init_act_valid(ctrl_init_act_valid), .ctrl_init_act_data(ctrl_init_act_data),
        .ctrl_start_mlp(ctrl_start_mlp), .ctrl_weights_ready(ctrl_weights_ready),
        .mlp_state(mlp_state), .mlp_cycle_cnt(mlp_cycle_cnt),
        .mlp_acc0(mlp_acc0), .mlp_acc1(mlp_acc1),
        .err_overrun(err_overrun), .err_badop(err_badop)
    );

    int vectors = 0, miscompares = 0;

    // Reference model: bytes of the command being assembled, and the readback bytes still owed.
    byte unsigned cmd[$];
    byte unsigned txq[$];
    bit           m_ovr, m_bad;
    bit           e_p0, e_p1, e_wrst, e_actv, e_start, e_wrdy;
    logic [7:0]   e_wdata;
    logic [15:0]  e_actd;
`ifdef UART_CMD_TIMEOUT_EN
    int           idle_cnt;
`endif

    int           n_push0 = 0, n_push1 = 0, n_start = 0, n_act = 0;
    byte unsigned txlog[$];
    bit           rand_mlp = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        cmd.delete(); txq.delete();
        m_ovr = 0; m_bad = 0;
        e_p0 = 0; e_p1 = 0; e_wrst = 0; e_actv = 0; e_start = 0; e_wrdy = 0;
        e_wdata = 8'h00; e_actd = 16'h0000;
`ifdef UART_CMD_TIMEOUT_EN
        idle_cnt = 0;
`endif
    endfunction

    function automatic void model_step(input bit rxv, input byte unsigned rxd, input bit txr);
        int op;
        e_p0 = 0; e_p1 = 0; e_wrst = 0; e_actv = 0; e_start = 0; e_wrdy = 0;
        if (txq.size() != 0) begin
            if (rxv) m_ovr = 1;
            if (txr) void'(txq.pop_front());
        end else if (rxv) begin
`ifdef UART_CMD_TIMEOUT_EN
            idle_cnt = 0;
`endif
            cmd.push_back(rxd);
            op = cmd[0];
            case (op)
                1, 2: begin
                    if (cmd.size() == 2) begin
                        if (rxd == 0) cmd.delete();
                    end else if (cmd.size() > 2) begin
                        if (op == 1) e_p0 = 1; else e_p1 = 1;
                        e_wdata = rxd;
                        if (cmd.size() == cmd[1] + 2) cmd.delete();
                    end
                end
                3: if (cmd.size() == 3) begin
                    e_actv = 1;
                    e_actd = {cmd[2], cmd[1]};
                    cmd.delete();
                end
                4: begin e_wrdy = 1; cmd.delete(); end
                5: begin e_start = 1; cmd.delete(); end
                8: begin e_wrst = 1; cmd.delete(); end
                9: begin m_ovr = 0; m_bad = 0; cmd.delete(); end
                6: begin
                    txq.push_back({4'h0, mlp_state});
                    txq.push_back({m_ovr, m_bad, 1'b0, mlp_cycle_cnt});
                    cmd.delete();
                end
                7: begin
                    for (int i = 0; i < 4; i++) txq.push_back(mlp_acc0[8*i +: 8]);
                    for (int i = 0; i < 4; i++) txq.push_back(mlp_acc1[8*i +: 8]);
                    cmd.delete();
                end
                default: begin m_bad = 1; cmd.delete(); end
            endcase
        end else if (cmd.size() != 0) begin
`ifdef UART_CMD_TIMEOUT_EN
            idle_cnt++;
            if (idle_cnt == 16) begin
                cmd.delete();
                m_bad = 1;
                idle_cnt = 0;
            end
`endif
        end
    endfunction

    task automatic check();
        vectors++;
        chk("push_col0", ctrl_wf_push_col0, e_p0);
        chk("push_col1", ctrl_wf_push_col1, e_p1);
        chk("wf_data_in", ctrl_wf_data_in, e_wdata);
        chk("wf_reset", ctrl_wf_reset, e_wrst);
        chk("act_valid", ctrl_init_act_valid, e_actv);
        chk("act_data", ctrl_init_act_data, e_actd);
        chk("start_mlp", ctrl_start_mlp, e_start);
        chk("weights_ready", ctrl_weights_ready, e_wrdy);
        chk("err_overrun", err_overrun, m_ovr);
        chk("err_badop", err_badop, m_bad);
        chk("tx_valid", tx_valid, txq.size() != 0);
        if (txq.size() != 0) chk("tx_data", tx_data, txq[0]);
        if (ctrl_wf_push_col0)   n_push0++;
        if (ctrl_wf_push_col1)   n_push1++;
        if (ctrl_start_mlp)      n_start++;
        if (ctrl_init_act_valid) n_act++;
    endtask

    task automatic tick(input bit rxv, input logic [7:0] rxd, input bit txr);
        rx_valid = rxv;
        rx_data  = rxd;
        tx_ready = txr;
        if (rand_mlp) begin
            mlp_state     = 4'($urandom);
            mlp_cycle_cnt = 5'($urandom);
            mlp_acc0      = $urandom;
            mlp_acc1      = $urandom;
        end
        if (tx_valid && tx_ready) txlog.push_back(tx_data);
        @(posedge clk);
        model_step(rxv, rxd, txr);
        #1;
        check();
    endtask

    task automatic rtick(input bit rxv, input logic [7:0] rxd);
        tick(rxv, rxd, $urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [7:0] b);
        tick(1'b1, b, 1'b1);
    endtask

    task automatic idle(input int n, input bit txr);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, txr);
    endtask

    initial begin
        byte unsigned acc_exp[8];
        byte unsigned b[$];
        logic [7:0]   b1;
        int           k, n, p0;

        model_reset();
        #12;
        check();
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_push0", ctrl_wf_push_col0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2, 1'b1);

        // Column-0 weight load.
        n_push0 = 0; n_push1 = 0;
        send(8'h01); send(8'h03); send(8'hAA); send(8'hBB); send(8'hCC);
        idle(2, 1'b1);
        chk("dir_push0_cnt", n_push0, 3);
        chk("dir_push1_cnt", n_push1, 0);
        chk("dir_wdata_last", ctrl_wf_data_in, 8'hCC);

        // Activation word, then an empty column-1 load.
        n_act = 0;
        send(8'h03); send(8'h34); send(8'h12);
        idle(1, 1'b1);
        chk("dir_act_cnt", n_act, 1);
        chk("dir_act_data", ctrl_init_act_data, 16'h1234);
        send(8'h02); send(8'h00);
        idle(2, 1'b1);
        chk("dir_len0_push1", n_push1, 0);

        // Accumulator readback with a stalling receiver.
        rand_mlp = 1'b0;
        mlp_acc0 = 32'h80000001;
        mlp_acc1 = 32'h00000002;
        acc_exp = '{8'h01, 8'h00, 8'h00, 8'h80, 8'h02, 8'h00, 8'h00, 8'h00};
        send(8'h07);
        txlog.delete();
        for (int i = 0; i < 20; i++) tick(1'b0, 8'h00, i[0]);
        chk("dir_acc_len", txlog.size(), 8);
        for (int i = 0; i < 8 && i < txlog.size(); i++) chk("dir_acc_byte", txlog[i], acc_exp[i]);

        // Byte during TX is dropped and flagged.
        n_start = 0;
        send(8'h07);
        tick(1'b1, 8'h05, 1'b0);
        idle(12, 1'b1);
        chk("dir_overrun_start", n_start, 0);
        chk("dir_overrun_flag", err_overrun, 1'b1);
        txlog.delete();
        send(8'h06);
        idle(4, 1'b1);
        chk("dir_status_len", txlog.size(), 2);
        if (txlog.size() > 1) begin
            b1 = txlog[1];
            chk("dir_status_ovr_bit", b1[7], 1'b1);
        end
        send(8'h09);
        idle(1, 1'b1);
        chk("dir_clr_overrun", err_overrun, 1'b0);

        // Undefined opcode.
        send(8'hFF);
        idle(1, 1'b1);
        chk("dir_badop", err_badop, 1'b1);
        send(8'h09);
        idle(1, 1'b1);
        chk("dir_clr_badop", err_badop, 1'b0);

`ifdef UART_CMD_TIMEOUT_EN
        p0 = n_push0;
        send(8'h01); send(8'h02); send(8'hAA);
        idle(20, 1'b1);
        chk("dir_tmo_pushes", n_push0 - p0, 1);
        chk("dir_tmo_badop", err_badop, 1'b1);
        send(8'h09);
`endif

        // Asynchronous reset in the middle of a weight load.
        send(8'h01); send(8'h05); send(8'h11); send(8'h22);
        rx_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check();
        chk("dir_rst_wdata", ctrl_wf_data_in, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        n_start = 0;
        send(8'h05);
        chk("dir_post_rst_start", n_start, 1);
        idle(1, 1'b1);

        // Randomized command stream.
        rand_mlp = 1'b1;
        for (int c = 0; c < 400; c++) begin
            b.delete();
            k = $urandom_range(0, 19);
            if (k < 6) begin
                n = $urandom_range(0, 5);
                b.push_back((k < 3) ? 8'h01 : 8'h02);
                b.push_back(8'(n));
                for (int i = 0; i < n; i++) b.push_back(8'($urandom));
            end else if (k < 9) begin
                b.push_back(8'h03); b.push_back(8'($urandom)); b.push_back(8'($urandom));
            end else if (k < 15) begin
                b.push_back(8'($urandom_range(4, 9)));
            end else if (k < 18) begin
                b.push_back(($urandom_range(0, 1) != 0) ? 8'h06 : 8'h07);
            end else begin
                b.push_back(($urandom_range(0, 1) != 0) ? 8'hFF : 8'(8'h0A + $urandom_range(0, 20)));
            end
            foreach (b[i]) begin
                n = $urandom_range(0, 3);
                for (int g = 0; g < n; g++) rtick(1'b0, 8'h00);
                rtick(1'b1, b[i]);
            end
        end
        idle(40, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Byte-level command controller that sits directly upstream of the TPU bridge. It decodes the host's UART byte stream and drives the bridge's `ctrl_*` inputs: weight-FIFO pushes and reset, initial activations, weights-ready and start pulses. It reads the MLP state, cycle count and accumulators back through the bridge and serialises them onto a UART TX byte handshake.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 100000: idle cycles allowed between bytes of one multi-byte command before the command is abandoned.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `rx_valid`  in  1  one-cycle strobe; a received byte is present on `rx_data`.
- `rx_data`  in  8  received byte.
- `tx_valid` / `tx_ready` / `tx_data`  out / in / out  1 / 1 / 8  transmit byte handshake.
- `ctrl_wf_push_col0`, `ctrl_wf_push_col1`  out  1  weight-FIFO push strobes.
- `ctrl_wf_data_in`  out  8  weight byte.
- `ctrl_wf_reset`  out  1  weight-FIFO reset pulse.
- `ctrl_init_act_valid` / `ctrl_init_act_data`  out  1 / 16  activation word strobe and data.
- `ctrl_start_mlp`, `ctrl_weights_ready`  out  1  command pulses.
- `mlp_state` / `mlp_cycle_cnt`  in  4 / 5  MLP status.
- `mlp_acc0`, `mlp_acc1`  in  32 signed  accumulators.
- `err_overrun`, `err_badop`  out  1  sticky error flags.

## Operation
- Opcodes (first byte of every command):
  - 0x01 W_COL0 and 0x02 W_COL1: followed by length byte N, then N weight bytes. N=0 completes immediately.
  - 0x03 ACT: followed by two bytes, low byte then high byte.
  - 0x04 WREADY, 0x05 START, 0x08 WF_RESET: single byte; each produces its corresponding one-cycle pulse.
  - 0x06 RD_STATUS: transmits 2 bytes.
  - 0x07 RD_ACC: transmits 8 bytes.
  - 0x09 CLR_ERR: clears both error flags.
- Any other opcode: sets `err_badop`; the FSM stays in IDLE.
- States and transitions:
  - IDLE → LEN for 0x01/0x02.
  - LEN → WDATA if N≠0, else IDLE.
  - WDATA: 8-bit down-counter; each byte issues one push on the selected column; returns to IDLE after the Nth byte.
  - IDLE → ACT_LO → ACT_HI → IDLE. On the high byte, `ctrl_init_act_valid` pulses with `{hi,lo}`.
  - IDLE → TX for 0x06/0x07; TX → IDLE after the last byte is accepted.
- RD_STATUS bytes: byte0 = `{4'b0, mlp_state}`, byte1 = `{err_overrun, err_badop, 1'b0, mlp_cycle_cnt}`.
- RD_ACC bytes: `mlp_acc0` then `mlp_acc1`, each little-endian.
- All status and accumulator values are snapshotted into a register in the cycle the opcode is decoded. Later MLP changes do not affect bytes already queued.
- A byte received while in TX is dropped and sets `err_overrun`. The TX transfer continues.
- Pulse outputs are single-cycle. At most one pulse is active in any cycle.

## Timing
- All outputs are registered. Reset value of every output is 0; FSM resets to IDLE; counters and snapshot reset to 0.
- Pulse latency: each output pulse is asserted the cycle after the `rx_valid` that completes the triggering byte. `ctrl_wf_data_in` holds the byte while the push is high, and holds its value afterwards.
- TX latency: `tx_valid` rises the cycle after the opcode.
  - `tx_data` is stable while `tx_valid && !tx_ready`.
  - A byte transfers on `tx_valid && tx_ready`. The next byte is presented the following cycle with no bubble.
- `tx_ready` low indefinitely: the block stalls in TX. No timeout applies in TX.
- CLR_ERR in the same cycle as a new error: set wins.
- Reset asserted mid-command: immediate return to IDLE. Partial weight pushes already issued are not undone.

## Configuration
- `UART_CMD_TIMEOUT_EN` defined:
  - In LEN, WDATA, ACT_LO and ACT_HI, a counter counts cycles since the last `rx_valid`.
  - When it reaches `TIMEOUT_CYCLES`, the FSM returns to IDLE, sets `err_badop`, and issues no pulse.
- Without the macro: no counter; the FSM waits indefinitely for the next byte.

## Structure
- Package `tpu_uart_pkg`:
  - opcode enum (8-bit);
  - FSM state enum;
  - `RD_STATUS_LEN` = 2 and `RD_ACC_LEN` = 8 constants.
- Sub-module `cmd_tx_sequencer` holds the 64-bit snapshot, the byte index and the `tx_valid`/`tx_data` handshake. It is loaded by the main FSM with a length and snapshot, and returns `done`.

## Test plan
- 01 03 AA BB CC → push_col0 pulses 3 times with data AA, BB, CC, one cycle after each byte; push_col1 never asserts.
- 03 34 12 → single `ctrl_init_act_valid` pulse with data 0x1234; 02 00 → no push, FSM back in IDLE.
- `mlp_acc0`=0x80000001, `mlp_acc1`=0x00000002, send 07 with `tx_ready` toggling 1/0 → bytes 01 00 00 80 02 00 00 00 in order; data stable during stalls.
- 07 then extra byte 05 during TX → no start pulse, `err_overrun`=1. RD_STATUS returns byte1 bit7 set. 09 clears the flag.
- Opcode 0xFF → `err_badop`=1, no outputs. With `UART_CMD_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16: 01 02 AA then silence → IDLE after 16 cycles, one push only.
- `rst_n` low while in WDATA → all outputs 0 asynchronously. Next 05 → `ctrl_start_mlp` pulse.
